// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU execute stage: op encodings,
// FSM state encoding and the signed-overflow helper.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLL = 3'd4,
        OP_SRL = 3'd5,
        OP_SRA = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // Signed overflow from operand and result sign bits; sub treats b as negated.
    function automatic logic add_sub_overflow(input logic a_msb, input logic b_msb,
                                              input logic r_msb, input logic sub);
        if (sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        else
            return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Operand/request/result bundle between the register bank, the ALU execute
// stage and writeback.
interface alu_exec_stage_if #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 10,
    parameter int SELW  = 4
);

    logic [NSRC*WIDTH-1:0] src_bus;
    logic [SELW-1:0]       sel1;
    logic [SELW-1:0]       sel2;
    logic                  use_din;
    logic [WIDTH-1:0]      din;
    logic [2:0]            op;
    logic                  start;

    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      result;
    logic                  zero;
    logic                  overflow;
    logic                  greaterThan;
    logic                  lessThan;

    modport master (
        output src_bus, sel1, sel2, use_din, din, op, start,
        input  busy, done, result, zero, overflow, greaterThan, lessThan
    );

    modport slave (
        input  src_bus, sel1, sel2, use_din, din, op, start,
        output busy, done, result, zero, overflow, greaterThan, lessThan
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per step,
// WIDTH steps per product.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic               last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] partial;

    // prod already includes the current step, so the caller can register it on last.
    assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod    = partial;
    assign last    = step && (count_q == CW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            acc_d    = '0;
            mplier_d = b;
            count_d  = '0;
        end else if (step) begin
            acc_d    = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: operand select, single-cycle ALU ops and a
// multi-cycle multiply behind a start/busy/done handshake.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NSRC  = 10,
    parameter int SELW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    alu_exec_stage_if.slave  bus
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   op_a, op_b, src2;
    logic [SHW-1:0]     shamt;
    alu_op_e            op;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               cmp_gt, cmp_lt;

    logic               mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0] mul_prod;

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               done_q, done_d;
    logic               mul_gt_q, mul_gt_d;
    logic               mul_lt_q, mul_lt_d;

    // Out-of-range select indices fall through to zero.
    always_comb begin
        op_a = '0;
        src2 = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.sel1 == SELW'(k)) op_a = bus.src_bus[k*WIDTH +: WIDTH];
            if (bus.sel2 == SELW'(k)) src2 = bus.src_bus[k*WIDTH +: WIDTH];
        end
        op_b = bus.use_din ? bus.din : src2;
    end

    assign op     = alu_op_e'(bus.op);
    assign shamt  = op_b[SHW-1:0];
    assign cmp_gt = $signed(op_a) > $signed(op_b);
    assign cmp_lt = $signed(op_a) < $signed(op_b);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = op_a + op_b;
                alu_ovf = add_sub_overflow(op_a[WIDTH-1], op_b[WIDTH-1], alu_res[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_ovf = add_sub_overflow(op_a[WIDTH-1], op_b[WIDTH-1], alu_res[WIDTH-1], 1'b1);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (mul_load),
        .step  (mul_step),
        .a     (op_a),
        .b     (op_b),
        .prod  (mul_prod),
        .last  (mul_last)
    );

    // Comparison flags for a multiply are captured at acceptance, since the
    // operand sources may change while the product is being built.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        done_d   = 1'b0;
        mul_gt_d = mul_gt_q;
        mul_lt_d = mul_lt_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (op == OP_MUL) begin
                        mul_load = 1'b1;
                        mul_gt_d = cmp_gt;
                        mul_lt_d = cmp_lt;
                        state_d  = ST_MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        gt_d     = cmp_gt;
                        lt_d     = cmp_lt;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = mul_prod[WIDTH-1:0];
                    zero_d   = (mul_prod[WIDTH-1:0] == '0);
                    ovf_d    = |mul_prod[2*WIDTH-1:WIDTH];
                    gt_d     = mul_gt_q;
                    lt_d     = mul_lt_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            done_q   <= 1'b0;
            mul_gt_q <= 1'b0;
            mul_lt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            done_q   <= done_d;
            mul_gt_q <= mul_gt_d;
            mul_lt_q <= mul_lt_d;
        end
    end

    assign bus.busy        = (state_q == ST_MUL);
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.overflow    = ovf_q;
    assign bus.greaterThan = gt_q;
    assign bus.lessThan    = lt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized
// ops checked against an arithmetic reference model.
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int NSRC  = 10;
    localparam int SELW  = 4;

    typedef struct packed {
        logic [15:0] result;
        logic        zero;
        logic        ovf;
        logic        gt;
        logic        lt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] src [NSRC];
    int          checks = 0;
    int          errors = 0;

    alu_exec_stage_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus ();

    alu_exec_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int k = 0; k < NSRC; k++) bus.src_bus[k*WIDTH +: WIDTH] = src[k];
    end

    function automatic logic [15:0] pick(input int s);
        return (s < NSRC) ? src[s] : 16'h0000;
    endfunction

    function automatic exp_t model(input int o, input logic [15:0] a, input logic [15:0] b);
        exp_t           e;
        int             sa, sb, s, sh;
        longint         full;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b % 16);
        s  = 0;
        e.ovf = 1'b0;
        case (o)
            0: begin s = sa + sb; e.ovf = (s > 32767) || (s < -32768); end
            1: begin s = sa - sb; e.ovf = (s > 32767) || (s < -32768); end
            2: s = int'(a & b);
            3: s = int'(a | b);
            4: s = int'(a) << sh;
            5: s = int'(a) >> sh;
            6: s = sa >>> sh;
            default: begin
                full  = longint'(a) * longint'(b);
                s     = int'(full % 65536);
                e.ovf = (full >= 65536);
            end
        endcase
        e.result = 16'(s);
        e.zero   = (e.result == 16'h0000);
        e.gt     = sa > sb;
        e.lt     = sa < sb;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        for (int k = 0; k < NSRC; k++) src[k] = 16'(k);
        bus.din     = 16'd10;
        bus.use_din = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic drive(input int s1, input int s2, input logic ud, input logic [2:0] o);
        bus.sel1    = 4'(s1);
        bus.sel2    = 4'(s2);
        bus.use_din = ud;
        bus.op      = o;
        bus.start   = 1'b1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.done === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] got;
        set_defaults();
        bus.sel1 = '0; bus.sel2 = '0; bus.op = '0;
        reset = 1'b1;
        step(); step();
        got = {bus.busy, bus.done, bus.zero, bus.overflow, bus.greaterThan, bus.lessThan, 1'b0};
        checks++;
        if (got !== 7'd0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 0000000", got);
        end
        checks++;
        if (bus.result !== 16'h0000) begin
            errors++; $display("[TB] FAIL reset_result: got %h expected 0000", bus.result);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_cycle();
        logic [19:0] got;
        set_defaults();
        drive(1, 2, 1'b0, OP_ADD); step(); bus.start = 1'b0;
        got = {bus.done, bus.result, bus.zero, bus.lessThan, bus.greaterThan};
        checks++;
        if (got !== {1'b1, 16'd3, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL add_basic: got %h expected %h", got, {1'b1, 16'd3, 3'b010});
        end
        step();
        checks++;
        if ({bus.done, bus.result} !== {1'b0, 16'd3}) begin
            errors++; $display("[TB] FAIL hold: got done=%b result=%h expected done=0 result=0003", bus.done, bus.result);
        end

        drive(0, 0, 1'b1, OP_ADD); step(); bus.start = 1'b0;
        checks++;
        if ({bus.done, bus.result, bus.lessThan} !== {1'b1, 16'd10, 1'b1}) begin
            errors++; $display("[TB] FAIL add_din: got result=%h lt=%b expected 000a lt=1", bus.result, bus.lessThan);
        end

        src[0] = 16'h7FFF; bus.din = 16'd1;
        drive(0, 0, 1'b1, OP_ADD); step(); bus.start = 1'b0;
        got = {bus.done, bus.result, bus.overflow, bus.zero, bus.greaterThan};
        checks++;
        if (got !== {1'b1, 16'h8000, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL add_overflow: got %h expected %h", got, {1'b1, 16'h8000, 3'b101});
        end

        set_defaults();
        src[3] = 16'h8000; src[4] = 16'd4;
        drive(3, 4, 1'b0, OP_SRA); step(); bus.start = 1'b0;
        checks++;
        if ({bus.result, bus.overflow, bus.lessThan} !== {16'hF800, 1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL sra: got result=%h ovf=%b lt=%b expected f800 0 1", bus.result, bus.overflow, bus.lessThan);
        end

        set_defaults();
        drive(1, 3, 1'b0, OP_SLL); step(); bus.start = 1'b0;
        checks++;
        if (bus.result !== 16'h0008) begin
            errors++; $display("[TB] FAIL sll: got %h expected 0008", bus.result);
        end

        drive(12, 2, 1'b0, OP_ADD); step(); bus.start = 1'b0;
        checks++;
        if ({bus.result, bus.lessThan, bus.greaterThan} !== {16'd2, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL sel_out_of_range: got result=%h lt=%b gt=%b expected 0002 1 0", bus.result, bus.lessThan, bus.greaterThan);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_r [3];
        logic [2:0]  ops [3];
        exp_r[0] = 16'd5; exp_r[1] = 16'd2; exp_r[2] = 16'd7;
        ops[0] = OP_SUB; ops[1] = OP_AND; ops[2] = OP_OR;
        set_defaults();
        for (int i = 0; i < 3; i++) begin
            drive(7, 2, 1'b0, ops[i]);
            step();
            checks++;
            if ({bus.done, bus.result, bus.greaterThan} !== {1'b1, exp_r[i], 1'b1}) begin
                errors++; $display("[TB] FAIL back_to_back[%0d]: got done=%b result=%h gt=%b expected 1 %h 1", i, bus.done, bus.result, bus.greaterThan, exp_r[i]);
            end
        end
        bus.start = 1'b0;
        step();
    endtask

    task automatic test_mul();
        int done_at;
        int busy_bad;
        int cyc;
        set_defaults();
        drive(7, 9, 1'b0, OP_MUL); step(); bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++; $display("[TB] FAIL mul_accept: got busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        done_at = -1; busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5 || k == 16) drive(7, 9, 1'b0, OP_ADD);
            step();
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                done_at = k;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
        end
        checks++;
        if (done_at != 16 || busy_bad != 0) begin
            errors++; $display("[TB] FAIL mul_latency: got done at %0d (%0d idle cycles) expected 16 (0)", done_at, busy_bad);
        end
        checks++;
        if ({bus.busy, bus.result, bus.overflow, bus.zero, bus.lessThan} !== {1'b0, 16'd63, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL mul_result: got busy=%b result=%h ovf=%b zero=%b lt=%b expected 0 003f 0 0 1", bus.busy, bus.result, bus.overflow, bus.zero, bus.lessThan);
        end
        step();
        checks++;
        if ({bus.done, bus.result} !== {1'b0, 16'd63}) begin
            errors++; $display("[TB] FAIL mul_completion_start: got done=%b result=%h expected 0 003f", bus.done, bus.result);
        end

        src[7] = 16'h0100; src[9] = 16'h0100;
        drive(7, 9, 1'b0, OP_MUL); step(); bus.start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc != 16 || {bus.result, bus.zero, bus.overflow} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++; $display("[TB] FAIL mul_wrap: got cycles=%0d result=%h zero=%b ovf=%b expected 16 0000 1 1", cyc, bus.result, bus.zero, bus.overflow);
        end
    endtask

    task automatic test_reset_mid_mul();
        int spurious;
        set_defaults();
        drive(7, 9, 1'b0, OP_MUL); step(); bus.start = 1'b0;
        for (int k = 1; k < 8; k++) step();
        reset = 1'b1;
        step();
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.greaterThan, bus.lessThan} !== 22'd0) begin
            errors++; $display("[TB] FAIL reset_mid_mul: got busy=%b done=%b result=%h expected 0 0 0000 with flags clear", bus.busy, bus.done, bus.result);
        end
        reset = 1'b0;
        drive(1, 2, 1'b0, OP_ADD); step(); bus.start = 1'b0;
        checks++;
        if ({bus.done, bus.result} !== {1'b1, 16'd3}) begin
            errors++; $display("[TB] FAIL add_after_reset: got done=%b result=%h expected 1 0003", bus.done, bus.result);
        end
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.done !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++; $display("[TB] FAIL aborted_mul_done: got %0d done pulses expected 0", spurious);
        end
    endtask

    task automatic test_random();
        logic [15:0] edge_vals [4];
        logic [15:0] a, b;
        logic [19:0] got;
        exp_t        e;
        int          s1, s2, o, cyc;
        logic        ud;
        edge_vals[0] = 16'h0000; edge_vals[1] = 16'h7FFF;
        edge_vals[2] = 16'h8000; edge_vals[3] = 16'hFFFF;
        set_defaults();
        for (int i = 0; i < 250; i++) begin
            for (int k = 0; k < NSRC; k++)
                src[k] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            bus.din = 16'($urandom);
            s1 = $urandom_range(0, 15);
            s2 = $urandom_range(0, 15);
            ud = 1'($urandom_range(0, 1));
            o  = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 6);
            a  = pick(s1);
            b  = ud ? bus.din : pick(s2);
            e  = model(o, a, b);
            drive(s1, s2, ud, 3'(o));
            step();
            bus.start = 1'b0;
            if (o == 7) begin
                for (int k = 0; k < NSRC; k++) src[k] = 16'($urandom);
                bus.din = 16'($urandom);
                wait_done(cyc);
                checks++;
                if (cyc != 16) begin
                    errors++; $display("[TB] FAIL rand_mul_latency[%0d]: got %0d expected 16", i, cyc);
                end
            end else begin
                checks++;
                if (bus.done !== 1'b1) begin
                    errors++; $display("[TB] FAIL rand_done[%0d]: got %b expected 1", i, bus.done);
                end
            end
            got = {bus.result, bus.zero, bus.overflow, bus.greaterThan, bus.lessThan};
            checks++;
            if (got !== e) begin
                errors++; $display("[TB] FAIL rand_op[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, got, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.sel1 = '0; bus.sel2 = '0; bus.op = '0;
        set_defaults();
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_mul();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
